// File: rtl/uart_tx_arbiter_if.sv
// Byte-request and serializer bus of the UART TX arbiter.
// master : requester/serializer side (drives req_valid/req_data/req_last,
//          tx_busy/tx_done; receives req_ready, tx_start, tx_data)
// slave  : arbiter side (the mirror image)
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_BITS = 8
);
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*DATA_BITS-1:0] req_data;
  logic [N_REQ-1:0]           req_last;
  logic [N_REQ-1:0]           req_ready;
  logic                       tx_start;
  logic [DATA_BITS-1:0]       tx_data;
  logic                       tx_busy;
  logic                       tx_done;

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of one uart_tx serializer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     per-requester valid/data/last/ready, serializer
//                   start/data/busy/done
//   grant_id        requester owning (or last owning) the line
//   locked          packet lock held between bytes of one packet
//   pkt_done        1-cycle pulse when a last byte completes
//   err_timeout     1-cycle pulse on watchdog abort
// Optional: define UART_ARB_WATCHDOG_EN to enable the tx_done watchdog.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  localparam int unsigned GRANT_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus,
  output logic [GRANT_W-1:0] grant_id,
  output logic               locked,
  output logic               pkt_done,
  output logic               err_timeout
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_e;

  // Elaboration-time configuration guard.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     ready_q, ready_d;
  logic                 start_q, start_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [GRANT_W-1:0]   rr_q, rr_d;
  logic                 locked_q, locked_d;
  logic                 last_q, last_d;
  logic                 pkt_q, pkt_d;

  logic [GRANT_W-1:0]   rr_inc;
  logic                 pick_found;
  logic [GRANT_W-1:0]   pick_idx;
  logic [GRANT_W-1:0]   scan_g;
  int unsigned          scan_idx;
  logic [DATA_BITS-1:0] req_bytes [N_REQ];

`ifdef UART_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Unpack the flat data bus into one byte per requester.
  always_comb begin : unpack_bytes
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_bytes[i] = bus.req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Pointer to the requester after the current owner, wrapping N_REQ-1 -> 0.
  always_comb begin : rr_next
    rr_inc = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  // Locked: only the holder may go. Unlocked: first valid from rr_q upward.
  always_comb begin : rr_pick
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    scan_g     = '0;
    if (locked_q) begin
      pick_found = bus.req_valid[grant_q];
      pick_idx   = grant_q;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        scan_idx = (32'(rr_q) + k) % N_REQ;
        scan_g   = GRANT_W'(scan_idx);
        if (!pick_found && bus.req_valid[scan_g]) begin
          pick_found = 1'b1;
          pick_idx   = scan_g;
        end
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : next_state
    state_d  = state_q;
    ready_d  = '0;
    start_d  = 1'b0;
    data_d   = data_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    locked_d = locked_q;
    last_d   = last_q;
    pkt_d    = 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
    wd_d     = wd_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!bus.tx_busy && pick_found) begin
          data_d  = req_bytes[pick_idx];
          start_d = 1'b1;
          ready_d = N_REQ'(1) << pick_idx;
          grant_d = pick_idx;
          last_d  = bus.req_last[pick_idx];
          state_d = WAIT_DONE;
`ifdef UART_ARB_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (last_q) begin
            locked_d = 1'b0;
            rr_d     = rr_inc;
            pkt_d    = 1'b1;
          end else begin
            locked_d = 1'b1;
          end
          state_d = IDLE;
`ifdef UART_ARB_WATCHDOG_EN
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Serializer never answered: drop the packet and free the line.
          err_d    = 1'b1;
          locked_d = 1'b0;
          rr_d     = rr_inc;
          state_d  = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      rr_q     <= '0;
      locked_q <= 1'b0;
      last_q   <= 1'b0;
      pkt_q    <= 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      pkt_q    <= pkt_d;
`ifdef UART_ARB_WATCHDOG_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.tx_start  = start_q;
  assign bus.tx_data   = data_q;
  assign grant_id      = grant_q;
  assign locked        = locked_q;
  assign pkt_done      = pkt_q;
`ifdef UART_ARB_WATCHDOG_EN
  assign err_timeout   = err_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule
